// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: requester and result channels of the shared logic unit arbiter
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [WIDTH*NUM_REQ-1:0] req_x;
  logic [WIDTH*NUM_REQ-1:0] req_y;
  logic res_valid;
  logic res_ready;
  logic [WIDTH-1:0] res_data;
  logic [ID_W-1:0] res_id;
  logic res_err;
  modport master (
    output req_valid, req_op, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );
  modport slave (
    input  req_valid, req_op, req_x, req_y, res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared registered logic unit; LU_ARB_PERF_EN adds perf_ops/perf_err counters
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  logic_unit_arbiter_if.slave bus
`ifdef LU_ARB_PERF_EN
  ,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_err
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] ptr, id_q, win, idx;
  logic [2:0] op_q;
  logic [WIDTH-1:0] x_q, y_q, data_q, lu;
  logic err_q, found, grant;
  // descending scan so the last hit is the first valid index at or after ptr
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign grant = (state == IDLE) && found && !rst;
  assign bus.req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb
    lu = (op_q == 3'd0) ? (x_q & y_q) :
         (op_q == 3'd1) ? (x_q | y_q) :
         (op_q == 3'd2) ? (x_q ^ y_q) :
         (op_q == 3'd3) ? ~(x_q & y_q) :
         (op_q == 3'd4) ? ~(x_q | y_q) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      id_q <= '0;
      op_q <= '0;
      x_q <= '0;
      y_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        id_q <= win;
        op_q <= bus.req_op[3*win +: 3];
        x_q <= bus.req_x[WIDTH*win +: WIDTH];
        y_q <= bus.req_y[WIDTH*win +: WIDTH];
      end
      if (state == EXEC) begin
        data_q <= lu;
        err_q <= op_q > 3'd4;
      end
    end
  end
  assign bus.res_valid = state == RESP;
  assign bus.res_data = data_q;
  assign bus.res_id = id_q;
  assign bus.res_err = err_q;
`ifdef LU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops <= '0;
      perf_err <= '0;
    end else if (bus.res_valid && bus.res_ready) begin
      perf_ops <= perf_ops + 16'd1;
      if (err_q) perf_err <= perf_err + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic_unit_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus();
`ifdef LU_ARB_PERF_EN
  logic [15:0] perf_ops, perf_err;
  logic [15:0] m_ops = '0, m_errs = '0;
`endif
  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LU_ARB_PERF_EN
    ,
    .perf_ops(perf_ops),
    .perf_err(perf_err)
`endif
  );
  int checks = 0, passed = 0, cyc = 0;
  int m_stage = 0, m_ptr = 0, m_id = 0;
  logic [W-1:0] m_data = '0;
  logic m_err = 1'b0;
  bit known = 0, just_reset = 0;
  int grants[$], gcyc[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  task automatic timeout(string name);
    checks++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask
  function automatic logic [W-1:0] lu_ref(int op, logic [W-1:0] x, logic [W-1:0] y);
    case (op)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x & y);
      4: return ~(x | y);
      default: return '0;
    endcase
  endfunction
  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    int w, op;
    logic [N-1:0] er;
    if (known) begin
      w = (m_stage == 0 && !rst) ? pick(bus.req_valid, m_ptr) : -1;
      er = (w >= 0) ? (N'(1) << w) : '0;
      chk("req_ready", bus.req_ready, er);
      chk("res_valid", bus.res_valid, m_stage == 2);
      if (m_stage == 2) begin
        chk("res_data", bus.res_data, m_data);
        chk("res_id", bus.res_id, m_id);
        chk("res_err", bus.res_err, m_err);
      end
      if (just_reset) begin
        chk("reset_data", bus.res_data, 0);
        chk("reset_id", bus.res_id, 0);
        chk("reset_err", bus.res_err, 0);
      end
`ifdef LU_ARB_PERF_EN
      chk("perf_ops", perf_ops, m_ops);
      chk("perf_err", perf_err, m_errs);
`endif
    end
    if (rst) begin
      m_stage = 0;
      m_ptr = 0;
      known = 1;
      just_reset = 1;
`ifdef LU_ARB_PERF_EN
      m_ops = '0;
      m_errs = '0;
`endif
    end else begin
      just_reset = 0;
      w = (m_stage == 0) ? pick(bus.req_valid, m_ptr) : -1;
      if (m_stage == 2 && bus.res_ready) begin
        m_stage = 0;
`ifdef LU_ARB_PERF_EN
        m_ops = m_ops + 16'd1;
        if (m_err) m_errs = m_errs + 16'd1;
`endif
      end else if (m_stage == 1) m_stage = 2;
      else if (m_stage == 0 && w >= 0) begin
        grants.push_back(w);
        gcyc.push_back(cyc);
        op = int'(bus.req_op[3*w +: 3]);
        m_data = lu_ref(op, bus.req_x[W*w +: W], bus.req_y[W*w +: W]);
        m_err = op > 4;
        m_id = w;
        m_ptr = (w + 1) % N;
        m_stage = 1;
      end
    end
  end
  task automatic wait_ready(int i, output bit ok);
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_ready[i];
    end
    if (!ok) timeout("wait_ready");
  endtask
  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      ok = bus.res_valid;
    end
    if (!ok) timeout("wait_valid");
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic set_req(int i, int op, logic [W-1:0] x, logic [W-1:0] y);
    bus.req_valid[i] = 1'b1;
    bus.req_op[3*i +: 3] = op[2:0];
    bus.req_x[W*i +: W] = x;
    bus.req_y[W*i +: W] = y;
  endtask
  task automatic send(int i, int op, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] ed, logic ee);
    bit ok;
    int t0;
    @(posedge clk);
    #1 set_req(i, op, x, y);
    wait_ready(i, ok);
    t0 = cyc;
    @(posedge clk);
    #1 bus.req_valid[i] = 1'b0;
    if (ok) begin
      wait_valid(ok);
      if (ok) begin
        chk("latency", cyc - t0, 2);
        chk("lit_data", bus.res_data, ed);
        chk("lit_id", bus.res_id, i);
        chk("lit_err", bus.res_err, ee);
      end
    end
  endtask
  initial begin
    bit ok;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 0, 4'hC, 4'hA, 4'h8, 1'b0);
    send(1, 1, 4'hC, 4'hA, 4'hE, 1'b0);
    send(1, 2, 4'hC, 4'hA, 4'h6, 1'b0);
    send(1, 3, 4'hC, 4'hA, 4'h7, 1'b0);
    send(1, 4, 4'hC, 4'hA, 4'h1, 1'b0);
    send(1, 6, 4'hC, 4'hA, 4'h0, 1'b1);
    do_reset();
    grants.delete();
    gcyc.delete();
    for (int i = 0; i < N; i++) set_req(i, i, 4'(i + 3), 4'hA);
    repeat (16) @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (5) @(posedge clk);
    if (grants.size() < 5) timeout("grant_count");
    else for (int k = 0; k < 5; k++) begin
      chk("grant_order", grants[k], k % 4);
      if (k > 0) chk("grant_spacing", gcyc[k] - gcyc[k-1], 3);
    end
    #1 bus.res_ready = 1'b0;
    set_req(3, 2, 4'h5, 4'h3);
    wait_ready(3, ok);
    @(posedge clk);
    #1 bus.req_valid = 4'b0011;
    wait_valid(ok);
    for (int n = 0; n < 10; n++) begin
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_data", bus.res_data, 4'h6);
      chk("bp_id", bus.res_id, 3);
      chk("bp_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.res_valid, 1);
    @(negedge clk);
    chk("bp_resume_ready", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (6) @(posedge clk);
    #1 set_req(2, 1, 4'h1, 4'h2);
    wait_ready(2, ok);
    @(posedge clk);
    #1 bus.req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 0, 4'hF, 4'h3);
    set_req(2, 1, 4'h1, 4'h2);
    @(negedge clk);
    chk("rst_no_resp", bus.res_valid, 0);
    chk("rst_ptr_grant", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (6) @(posedge clk);
`ifdef LU_ARB_PERF_EN
    do_reset();
    send(0, 0, 4'h3, 4'h5, 4'h1, 1'b0);
    send(1, 5, 4'h3, 4'h5, 4'h0, 1'b1);
    send(2, 2, 4'h3, 4'h5, 4'h6, 1'b0);
    send(3, 7, 4'h3, 4'h5, 4'h0, 1'b1);
    send(0, 4, 4'h3, 4'h5, 4'h8, 1'b0);
    repeat (2) @(negedge clk);
    chk("perf_ops_lit", perf_ops, 5);
    chk("perf_err_lit", perf_err, 2);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
